// File: rtl/img2col_reader.sv
// img2col_reader: walks the stored ifmap in img2col order and streams
// C*K*K-element columns (one per output pixel) to the GEMM array.
//
// Ports
//   clk, rstn            clock, async active-low reset
//   enable               global enable (freezes FSM and address issue)
//   conv_en              start pulse (sampled in IDLE)
//   cfg_h/w/c/k/s        ifmap H, W, channels C, kernel K, stride S
//   tensor_addr/t_addr_vld  buffer read port, data returns next cycle
//   tensor_data          buffer read data
//   col_data/valid/ready column stream, col_last / map_last markers
//   busy, done, cfg_err  status

module img2col_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SIZE  = 12,
  parameter int DIM_W      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  conv_en,
  input  logic [DIM_W-1:0]      cfg_h,
  input  logic [DIM_W-1:0]      cfg_w,
  input  logic [DIM_W-1:0]      cfg_c,
  input  logic [DIM_W-1:0]      cfg_k,
  input  logic [DIM_W-1:0]      cfg_s,
  output logic [ADDR_SIZE-1:0]  tensor_addr,
  output logic                  t_addr_vld,
  input  logic [DATA_WIDTH-1:0] tensor_data,
  output logic [DATA_WIDTH-1:0] col_data,
  output logic                  col_valid,
  input  logic                  col_ready,
  output logic                  col_last,
  output logic                  map_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int XW = DIM_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Plane and row-stride products, formed once when the config latches
  // so the walk itself only ever adds.
  function automatic logic [ADDR_SIZE-1:0] mul_a(
    input logic [DIM_W-1:0] a,
    input logic [DIM_W-1:0] b
  );
    logic [ADDR_SIZE-1:0] acc;
    logic [ADDR_SIZE-1:0] ext;
    acc = '0;
    ext = ADDR_SIZE'(a);
    for (int i = 0; i < DIM_W; i++) begin
      if (b[i]) acc = acc + ext;
      ext = ext << 1;
    end
    return acc;
  endfunction

  // Latched config
  logic [DIM_W-1:0]     h_q, w_q, c_q, k_q, s_q;
  logic [ADDR_SIZE-1:0] hw_q, sw_q;

  // Loop counters; oxs/oys hold ox*S and oy*S directly
  logic [DIM_W-1:0]     kx_q, ky_q, ch_q;
  logic [XW-1:0]        oxs_q, oys_q;

  // Base addresses for each loop level
  logic [ADDR_SIZE-1:0] addr_q, row_q, chn_q, pix_q, rb_q;

  // Read in flight and 2-entry output FIFO
  logic                  ifl_q, ifl_cl_q, ifl_ml_q;
  logic [DATA_WIDTH-1:0] fd_q [2];
  logic                  fcl_q [2];
  logic                  fml_q [2];
  logic                  rd_q, wr_q;
  logic [1:0]            occ_q;

  logic seen_q;
  logic err_q;

  logic legal, start, err_d;
  logic fire, pop, fpop, push;
  logic [2:0] level;

  logic kx_last, ky_last, c_last;
  logic ox_last, oy_last;
  logic el_cl, el_ml;

  logic [DATA_WIDTH-1:0] head_d;
  logic                  head_cl, head_ml;

  logic [ADDR_SIZE-1:0] wa, sa;
  logic [ADDR_SIZE-1:0] nxt_row, nxt_chn;
  logic [ADDR_SIZE-1:0] nxt_pix, nxt_rb;

  assign legal = (cfg_s != '0) && (cfg_k != '0) &&
                 (cfg_c != '0) &&
                 (cfg_k <= cfg_h) && (cfg_k <= cfg_w);

  assign kx_last = (kx_q == k_q - DIM_W'(1));
  assign ky_last = (ky_q == k_q - DIM_W'(1));
  assign c_last  = (ch_q == c_q - DIM_W'(1));

  // Next window would not fit inside the map
  assign ox_last = (oxs_q + XW'(s_q) + XW'(k_q)) > XW'(w_q);
  assign oy_last = (oys_q + XW'(s_q) + XW'(k_q)) > XW'(h_q);

  assign el_cl = kx_last & ky_last & c_last;
  assign el_ml = el_cl & ox_last & oy_last;

  assign wa      = ADDR_SIZE'(w_q);
  assign sa      = ADDR_SIZE'(s_q);
  assign nxt_row = row_q + wa;
  assign nxt_chn = chn_q + hw_q;
  assign nxt_pix = pix_q + sa;
  assign nxt_rb  = rb_q + sw_q;

  // Stream head: FIFO if occupied, else the read returning now
  always_comb begin
    head_d  = tensor_data;
    head_cl = ifl_cl_q;
    head_ml = ifl_ml_q;
    if (occ_q != 2'd0) begin
      head_d  = fd_q[rd_q];
      head_cl = fcl_q[rd_q];
      head_ml = fml_q[rd_q];
    end
  end

  assign col_valid = (occ_q != 2'd0) | ifl_q;
  assign col_data  = col_valid ? head_d : '0;
  assign col_last  = col_valid & head_cl;
  assign map_last  = col_valid & head_ml;

  assign pop  = col_valid & col_ready;
  assign fpop = pop & (occ_q != 2'd0);
  // A returning read that is consumed on bypass is not stored
  assign push = ifl_q & ~(pop & (occ_q == 2'd0));

  assign level = {1'b0, occ_q} + {2'b0, ifl_q} - {2'b0, pop};
  assign fire  = (state_q == S_RUN) & enable & (level < 3'd2);

  assign t_addr_vld  = fire;
  assign tensor_addr = addr_q;
  assign busy        = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign cfg_err     = err_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && conv_en) begin
          if (legal) begin
            start   = 1'b1;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (fire && el_ml) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (enable && (seen_q || (pop && head_ml)))
          state_d = S_DONE;
      end
      S_DONE: begin
        if (enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (start) begin
        seen_q <= 1'b0;
      end else if (pop && head_ml) begin
        seen_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_q    <= '0;
      w_q    <= '0;
      c_q    <= '0;
      k_q    <= '0;
      s_q    <= '0;
      hw_q   <= '0;
      sw_q   <= '0;
      kx_q   <= '0;
      ky_q   <= '0;
      ch_q   <= '0;
      oxs_q  <= '0;
      oys_q  <= '0;
      addr_q <= '0;
      row_q  <= '0;
      chn_q  <= '0;
      pix_q  <= '0;
      rb_q   <= '0;
    end else if (start) begin
      h_q    <= cfg_h;
      w_q    <= cfg_w;
      c_q    <= cfg_c;
      k_q    <= cfg_k;
      s_q    <= cfg_s;
      hw_q   <= mul_a(cfg_h, cfg_w);
      sw_q   <= mul_a(cfg_s, cfg_w);
      kx_q   <= '0;
      ky_q   <= '0;
      ch_q   <= '0;
      oxs_q  <= '0;
      oys_q  <= '0;
      addr_q <= '0;
      row_q  <= '0;
      chn_q  <= '0;
      pix_q  <= '0;
      rb_q   <= '0;
    end else if (fire) begin
      if (!kx_last) begin
        kx_q   <= kx_q + DIM_W'(1);
        addr_q <= addr_q + ADDR_SIZE'(1);
      end else begin
        kx_q <= '0;
        if (!ky_last) begin
          ky_q   <= ky_q + DIM_W'(1);
          row_q  <= nxt_row;
          addr_q <= nxt_row;
        end else begin
          ky_q <= '0;
          if (!c_last) begin
            ch_q   <= ch_q + DIM_W'(1);
            chn_q  <= nxt_chn;
            row_q  <= nxt_chn;
            addr_q <= nxt_chn;
          end else begin
            ch_q <= '0;
            if (!ox_last) begin
              oxs_q  <= oxs_q + XW'(s_q);
              pix_q  <= nxt_pix;
              chn_q  <= nxt_pix;
              row_q  <= nxt_pix;
              addr_q <= nxt_pix;
            end else begin
              oxs_q  <= '0;
              oys_q  <= oys_q + XW'(s_q);
              rb_q   <= nxt_rb;
              pix_q  <= nxt_rb;
              chn_q  <= nxt_rb;
              row_q  <= nxt_rb;
              addr_q <= nxt_rb;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifl_q    <= 1'b0;
      ifl_cl_q <= 1'b0;
      ifl_ml_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      occ_q    <= 2'd0;
      fd_q[0]  <= '0;
      fd_q[1]  <= '0;
      fcl_q[0] <= 1'b0;
      fcl_q[1] <= 1'b0;
      fml_q[0] <= 1'b0;
      fml_q[1] <= 1'b0;
    end else begin
      ifl_q    <= fire;
      ifl_cl_q <= fire & el_cl;
      ifl_ml_q <= fire & el_ml;
      if (push) begin
        fd_q[wr_q]  <= tensor_data;
        fcl_q[wr_q] <= ifl_cl_q;
        fml_q[wr_q] <= ifl_ml_q;
        wr_q        <= ~wr_q;
      end
      if (fpop) rd_q <= ~rd_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, fpop};
    end
  end

endmodule

// File: tb/tb_img2col_reader.sv
// tb_img2col_reader: random and directed checks of img2col_reader
// against a nested-loop img2col model and a small RAM model.

module tb_img2col_reader;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        conv_en;
  logic [7:0]  cfg_h, cfg_w, cfg_c, cfg_k, cfg_s;
  logic [11:0] tensor_addr;
  logic        t_addr_vld;
  logic [31:0] tensor_data;
  logic [31:0] col_data;
  logic        col_valid;
  logic        col_ready;
  logic        col_last;
  logic        map_last;
  logic        busy;
  logic        done;
  logic        cfg_err;

  img2col_reader #(
    .DATA_WIDTH(32),
    .ADDR_SIZE(12),
    .DIM_W(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .enable(enable),
    .conv_en(conv_en),
    .cfg_h(cfg_h),
    .cfg_w(cfg_w),
    .cfg_c(cfg_c),
    .cfg_k(cfg_k),
    .cfg_s(cfg_s),
    .tensor_addr(tensor_addr),
    .t_addr_vld(t_addr_vld),
    .tensor_data(tensor_data),
    .col_data(col_data),
    .col_valid(col_valid),
    .col_ready(col_ready),
    .col_last(col_last),
    .map_last(map_last),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        cl;
    logic        ml;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] recv[$];
  int          recv_cyc[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc_now = 0;
  int   done_cnt = 0;
  logic pdone = 0;
  logic pst = 0;
  logic [33:0] pv;
  logic [19:0] salt = 0;
  bit   rdy_mode = 0;
  bit   en_mode = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Buffer read port: one-cycle latency, data tagged with address
  always @(posedge clk)
    if (t_addr_vld) tensor_data <= {salt, tensor_addr};

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Reference img2col walk
  task automatic build(input int h, w, c, k, s);
    int oh, ow, a;
    exp_t e;
    exp_q.delete();
    oh = (h - k) / s + 1;
    ow = (w - k) / s + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int cc = 0; cc < c; cc++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              a = cc * h * w + (oy * s + ky) * w + ox * s + kx;
              a = a % 4096;
              e.d  = {salt, 12'(a)};
              e.cl = (kx == k-1) && (ky == k-1) && (cc == c-1);
              e.ml = e.cl && (ox == ow-1) && (oy == oh-1);
              exp_q.push_back(e);
            end
  endtask

  // Stream compare
  always @(negedge clk) begin
    exp_t e;
    if (rstn && col_valid && col_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_elem: got %0h, expected none",
                 col_data);
      end else begin
        e = exp_q.pop_front();
        chk("stream", {30'b0, col_data, col_last, map_last},
            {30'b0, e.d, e.cl, e.ml});
      end
      recv.push_back(col_data[11:0]);
      recv_cyc.push_back(cyc_now);
    end
  end

  // Held stream must not change while stalled
  always @(negedge clk) begin
    if (!rstn) begin
      pst = 0;
    end else begin
      if (pst)
        chk("stall_stable",
            {29'b0, col_valid, col_data, col_last, map_last},
            {29'b0, 1'b1, pv});
      pst = col_valid && !col_ready;
      pv  = {col_data, col_last, map_last};
    end
  end

  always @(negedge clk) begin
    if (rstn && done && !pdone) begin
      done_cnt++;
      chk("done_busy_low", {63'b0, busy}, 64'd0);
      chk("done_all_sent", exp_q.size(), 64'd0);
    end
    pdone = done;
  end

  initial begin
    col_ready = 1;
    enable = 1;
    forever begin
      @(posedge clk);
      #1;
      col_ready = rdy_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      enable = en_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic all_zero(input string nm);
    chk(nm, {13'b0, tensor_addr, t_addr_vld, col_data, col_valid,
             col_last, map_last, busy, done, cfg_err}, 64'd0);
  endtask

  task automatic start_pulse(input int h, w, c, k, s);
    @(posedge clk);
    #1;
    cfg_h = 8'(h);
    cfg_w = 8'(w);
    cfg_c = 8'(c);
    cfg_k = 8'(k);
    cfg_s = 8'(s);
    conv_en = 1;
    @(posedge clk);
    #1;
    conv_en = 0;
  endtask

  task automatic run_cfg(input int h, w, c, k, s,
                         input bit rnd, input bit poke);
    int n, cyc, dcnt, budget;
    salt = 20'($urandom);
    build(h, w, c, k, s);
    n = exp_q.size();
    recv.delete();
    recv_cyc.delete();
    rdy_mode = rnd;
    en_mode = 0;
    dcnt = done_cnt;
    budget = n * 16 + 64;
    start_pulse(h, w, c, k, s);
    cfg_h = 8'($urandom);
    cfg_w = 8'($urandom);
    cfg_k = 8'($urandom);
    if (!rnd) begin
      @(negedge clk);
      chk("start_issue", {50'b0, t_addr_vld, busy, tensor_addr},
          {50'b0, 1'b1, 1'b1, 12'h0});
      @(negedge clk);
      chk("first_valid", {63'b0, col_valid}, 64'd1);
    end
    en_mode = rnd;
    cyc = 0;
    while ((exp_q.size() != 0 || done_cnt == dcnt) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 8) begin
        conv_en = 1;
        cfg_h = 8'd5;
        cfg_w = 8'd5;
        cfg_c = 8'd2;
        cfg_k = 8'd2;
        cfg_s = 8'd2;
      end else begin
        conv_en = 0;
      end
    end
    conv_en = 0;
    chk("in_budget", {63'b0, cyc < budget}, 64'd1);
    en_mode = 0;
    rdy_mode = 0;
    repeat (4) @(negedge clk);
    chk("one_done", done_cnt - dcnt, 64'd1);
    chk("count", recv.size(), n);
  endtask

  initial begin
    int k, h, w, c, s, cnt, cyc;
    int ill[4][5];
    rstn = 0;
    conv_en = 0;
    cfg_h = 0;
    cfg_w = 0;
    cfg_c = 0;
    cfg_k = 0;
    cfg_s = 0;
    #1;
    all_zero("reset_state");
    repeat (3) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    all_zero("idle_after_reset");

    // Model pins for the basic walk
    build(4, 4, 1, 3, 1);
    chk("model_len", exp_q.size(), 64'd36);

    // Basic walk, with an ignored start mid-run
    run_cfg(4, 4, 1, 3, 1, 0, 1);
    if (recv.size() == 36) begin
      chk("b_e0", recv[0], 0);
      chk("b_e3", recv[3], 4);
      chk("b_e8", recv[8], 10);
      chk("b_e9", recv[9], 1);
      chk("b_e17", recv[17], 11);
      chk("b_e27", recv[27], 5);
      chk("b_contig", recv_cyc[35] - recv_cyc[0], 35);
    end

    // Stride
    run_cfg(5, 5, 1, 3, 2, 0, 0);
    if (recv.size() == 36) begin
      chk("s_col1", recv[9], 2);
      chk("s_col2", recv[18], 10);
      chk("s_col3", recv[27], 12);
    end

    // Multi-channel single column
    run_cfg(3, 3, 2, 3, 1, 0, 0);
    if (recv.size() == 18) begin
      chk("m_e9", recv[9], 9);
      chk("m_e17", recv[17], 17);
    end

    // Single element map
    run_cfg(1, 1, 1, 1, 1, 0, 0);

    // Backpressure and enable toggling
    run_cfg(4, 4, 1, 3, 1, 1, 0);
    if (recv.size() == 36) begin
      chk("bp_e9", recv[9], 1);
      chk("bp_e35", recv[35], 15);
    end

    // Illegal configs: K>H, S=0, C=0, K=0
    ill = '{'{4, 4, 1, 5, 1}, '{4, 4, 1, 3, 0},
            '{4, 4, 0, 3, 1}, '{4, 4, 1, 0, 1}};
    for (int i = 0; i < 4; i++) begin
      start_pulse(ill[i][0], ill[i][1], ill[i][2],
                  ill[i][3], ill[i][4]);
      @(negedge clk);
      chk("err_pulse", {61'b0, cfg_err, t_addr_vld, busy},
          {61'b0, 3'b100});
      cnt = 0;
      repeat (5) begin
        @(negedge clk);
        cnt += int'(cfg_err) + int'(t_addr_vld) + int'(busy);
      end
      chk("err_quiet", cnt, 0);
    end

    // Reset mid-run at element 10
    salt = 20'($urandom);
    build(4, 4, 1, 3, 1);
    recv.delete();
    start_pulse(4, 4, 1, 3, 1);
    cyc = 0;
    while (recv.size() < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach10", {63'b0, cyc < 200}, 64'd1);
    #2;
    rstn = 0;
    #1;
    all_zero("reset_midrun");
    exp_q.delete();
    repeat (2) @(negedge clk);
    all_zero("reset_hold");
    rstn = 1;
    run_cfg(4, 4, 1, 3, 1, 0, 0);
    if (recv.size() == 36)
      chk("rst_restart", recv[0], 0);

    // Random legal configs under backpressure
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(1, 3);
      h = k + $urandom_range(0, 5);
      w = k + $urandom_range(0, 5);
      c = $urandom_range(1, 3);
      s = $urandom_range(1, 3);
      run_cfg(h, w, c, k, s, 1, 0);
    end

    // Address wrap past 2^12
    run_cfg(40, 40, 3, 2, 3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
